// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding, reset
// instruction and the opcode/funct field positions handed to Main_Decoder.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_FETCH = 2'd1,
        S_ISSUE = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam int OP_LSB = 0;
    localparam int OP_W   = 6;
    localparam int F_LSB  = 12;
    localparam int F_W    = 3;

endpackage

// File: rtl/fetch_unit_next_pc_sel.sv
// Next-PC selection: jalr target, PC-relative branch/jump target or
// sequential pc+4, in that priority. Purely combinational.
module next_pc_sel #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] alu_result,
    input  logic            PCSrc,
    input  logic            Jalr,
    output logic [XLEN-1:0] next_pc,
    output logic [XLEN-1:0] pc_plus4
);

    // NOTE: every output is given a value before any branch, so no path
    // through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        pc_plus4 = pc + XLEN'(4);
        next_pc  = pc_plus4;
        if (Jalr) begin
            // jalr targets always have bit 0 cleared
            next_pc = alu_result & ~XLEN'(1);
        end else if (PCSrc) begin
            next_pc = pc + imm;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage feeding Main_Decoder. Optional misaligned-target
// trap is enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    parameter logic [XLEN-1:0] TRAP_PC  = 32'h0000_0100
`endif
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_ready,
    output logic [31:0]     instr,
    output logic [5:0]      op,
    output logic [2:0]      F,
    output logic            instr_valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    input  logic            PCSrc,
    input  logic            Jalr,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] alu_result,
    input  logic            ex_done
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic            misalign
`endif
);

    fetch_state_t    state, state_next;
    logic [XLEN-1:0] next_pc;
    logic [XLEN-1:0] pc_load;

    next_pc_sel #(.XLEN(XLEN)) u_next_pc_sel (
        .pc         (pc),
        .imm        (imm),
        .alu_result (alu_result),
        .PCSrc      (PCSrc),
        .Jalr       (Jalr),
        .next_pc    (next_pc),
        .pc_plus4   (pc_plus4)
    );

`ifdef FETCH_MISALIGN_TRAP_EN
    logic trap;
    assign trap    = (next_pc[1:0] != 2'b00);
    assign pc_load = trap ? TRAP_PC : next_pc;
`else
    assign pc_load = next_pc;
`endif

    assign imem_addr = pc;
    assign op        = instr[OP_LSB +: OP_W];
    assign F         = instr[F_LSB +: F_W];

    always_comb begin
        state_next = state;
        imem_req   = 1'b0;
        case (state)
            S_RESET: state_next = S_FETCH;
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) state_next = S_ISSUE;
            end
            S_ISSUE: if (ex_done) state_next = S_FETCH;
            default: state_next = S_RESET;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_RESET;
            pc          <= RESET_PC;
            instr       <= NOP_INSTR;
            instr_valid <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign    <= 1'b0;
`endif
        end else begin
            state <= state_next;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign <= 1'b0;
`endif
            if (state == S_FETCH && imem_ready) begin
                instr       <= imem_rdata;
                instr_valid <= 1'b1;
            end
            if (state == S_ISSUE && ex_done) begin
                pc          <= pc_load;
                instr_valid <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
                misalign    <= trap;
`endif
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed stimulus pushes expected issued
// instructions into a scoreboard that a negedge monitor pops and compares.
module tb_fetch_unit;
    import fetch_pkg::*;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] instr;
    logic [5:0]  op;
    logic [2:0]  F;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        PCSrc;
    logic        Jalr;
    logic [31:0] imm;
    logic [31:0] alu_result;
    logic        ex_done;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misalign;
`endif

    fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_ready  (imem_ready),
        .instr       (instr),
        .op          (op),
        .F           (F),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .PCSrc       (PCSrc),
        .Jalr        (Jalr),
        .imm         (imm),
        .alu_result  (alu_result),
        .ex_done     (ex_done)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .misalign    (misalign)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc_plus4;
        logic [5:0]  op;
        logic [2:0]  F;
    } exp_t;

    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else passed++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Fetch one word; the DUT must already be in S_FETCH at the given pc.
    task automatic fetch(input logic [31:0] exp_pc, input logic [31:0] word,
                         input logic [5:0] exp_op, input logic [2:0] exp_f);
        exp_t e;
        e.pc = exp_pc; e.instr = word; e.pc_plus4 = exp_pc + 32'd4;
        e.op = exp_op; e.F = exp_f;
        sb.push_back(e);
        imem_rdata = word;
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        check("valid_after_fetch", {31'd0, instr_valid}, 32'd1);
    endtask

    task automatic retire(input logic pcsrc, input logic jalr, input logic [31:0] i,
                          input logic [31:0] alu, input logic [31:0] exp_addr, input string name);
        PCSrc = pcsrc; Jalr = jalr; imm = i; alu_result = alu; ex_done = 1'b1;
        tick();
        ex_done = 1'b0; PCSrc = 1'b0; Jalr = 1'b0;
        check(name, imem_addr, exp_addr);
        check("req_after_retire", {31'd0, imem_req}, 32'd1);
        check("valid_after_retire", {31'd0, instr_valid}, 32'd0);
    endtask

    // Monitor: every rising instr_valid must match the oldest expected issue.
    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (instr_valid === 1'b1 && !prev_valid) begin
            if (sb.size() == 0) begin
                total++;
                $display("FAIL unexpected_issue: got pc %h expected no issue", pc);
            end else begin
                e = sb.pop_front();
                check("issue_pc", pc, e.pc);
                check("issue_instr", instr, e.instr);
                check("issue_op", {26'd0, op}, {26'd0, e.op});
                check("issue_F", {29'd0, F}, {29'd0, e.F});
                check("issue_pc_plus4", pc_plus4, e.pc_plus4);
            end
        end
        prev_valid = (instr_valid === 1'b1);
    end

    initial begin
        rst = 1'b1; imem_rdata = 32'd0; imem_ready = 1'b0;
        PCSrc = 1'b0; Jalr = 1'b0; imm = 32'd0; alu_result = 32'd0; ex_done = 1'b0;
        tick();
        tick();
        check("rst_pc", pc, 32'h0);
        check("rst_instr", instr, 32'h0000_0013);
        check("rst_op", {26'd0, op}, {26'd0, 6'b010011});
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_req", {31'd0, imem_req}, 32'd0);

        // Ready from the first fetch cycle: valid two edges after rst drops.
        rst = 1'b0;
        tick();
        check("fetch0_req", {31'd0, imem_req}, 32'd1);
        check("fetch0_addr", imem_addr, 32'h0);
        check("fetch0_valid", {31'd0, instr_valid}, 32'd0);
        fetch(32'h0, 32'h0000_0033, 6'b110011, 3'b000);

        // Sequential retire, then a store word.
        retire(1'b0, 1'b0, 32'd0, 32'd0, 32'h4, "seq_addr");
        fetch(32'h4, 32'h0020_2023, 6'b100011, 3'b010);
        retire(1'b0, 1'b0, 32'd0, 32'd0, 32'h8, "seq_addr2");
        fetch(32'h8, 32'h0000_0063, 6'b100011, 3'b000);

        // Backward branch from 0x8 by -8.
        retire(1'b1, 1'b0, 32'hFFFF_FFF8, 32'd0, 32'h0, "branch_addr");
        fetch(32'h0, 32'h0000_0067, 6'b100111, 3'b000);
        check("pc_plus4_before_jalr", pc_plus4, 32'h4);

        // Jalr wins over PCSrc and clears bit 0.
        retire(1'b1, 1'b1, 32'h0000_0010, 32'h0000_0041, 32'h40, "jalr_addr");

        // Memory stall at 0x40; ex_done while fetching must be ignored.
        for (int c = 1; c <= 2; c++) begin
            ex_done = 1'b1; PCSrc = 1'b1; imm = 32'h100;
            tick();
            check("stall_req", {31'd0, imem_req}, 32'd1);
            check("stall_valid", {31'd0, instr_valid}, 32'd0);
            check("stall_pc", pc, 32'h40);
        end
        ex_done = 1'b0; PCSrc = 1'b0;
        // Cycle 3: reset with a simultaneous ready; the data must be dropped.
        rst = 1'b1; imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        rst = 1'b0; imem_ready = 1'b0;
        check("stall_rst_pc", pc, 32'h0);
        check("stall_rst_valid", {31'd0, instr_valid}, 32'd0);
        check("stall_rst_instr", instr, 32'h0000_0013);
        check("stall_rst_req", {31'd0, imem_req}, 32'd0);
        tick();
        check("post_rst_req", {31'd0, imem_req}, 32'd1);
        tick();
        check("post_rst_valid", {31'd0, instr_valid}, 32'd0);
        check("post_rst_addr", imem_addr, 32'h0);
        fetch(32'h0, 32'h0000_0013, 6'b010011, 3'b000);

        // Wrap-around: jalr to 0xFFFF_FFFC, then pc+4 wraps to 0.
        retire(1'b0, 1'b1, 32'd0, 32'hFFFF_FFFD, 32'hFFFF_FFFC, "jalr_top_addr");
        fetch(32'hFFFF_FFFC, 32'h0000_0013, 6'b010011, 3'b000);
        retire(1'b0, 1'b0, 32'd0, 32'd0, 32'h0, "wrap_addr");

        fetch(32'h0, 32'h0000_1063, 6'b100011, 3'b001);
`ifdef FETCH_MISALIGN_TRAP_EN
        check("misalign_idle", {31'd0, misalign}, 32'd0);
        retire(1'b1, 1'b0, 32'h6, 32'd0, 32'h100, "trap_addr");
        check("misalign_pulse", {31'd0, misalign}, 32'd1);
        tick();
        check("misalign_clear", {31'd0, misalign}, 32'd0);
        check("trap_pc_hold", pc, 32'h100);
`else
        retire(1'b1, 1'b0, 32'h6, 32'd0, 32'h6, "unaligned_addr");
`endif

        tick();
        tick();
        check("scoreboard_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage sitting directly upstream of Main_Decoder in the control unit.
- Holds the PC and issues requests to instruction memory over a ready handshake.
- Latches the returned word and presents op[5:0] and F[2:0] to the decoder.
- On each retire it computes the next PC from the decoder's PCSrc/Jalr outputs, then fetches again.

Parameters:
- XLEN, 32, width of the PC, addresses and instruction word.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TRAP_PC, 32'h0000_0100, redirect target when FETCH_MISALIGN_TRAP_EN is defined.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  XLEN  fetch address; always equals pc.
- imem_rdata  input  32  instruction word; valid when imem_ready=1.
- imem_ready  input  1  memory has accepted the request and returned data this cycle.
- instr  output  32  latched instruction.
- op  output  6  instr[5:0], to Main_Decoder op.
- F  output  3  instr[14:12], to Main_Decoder F.
- instr_valid  output  1  instr/op/F are valid for the current PC.
- pc  output  XLEN  PC of the latched instruction.
- pc_plus4  output  XLEN  pc+4 (jal/jalr link value).
- PCSrc  input  1  from Main_Decoder: take a PC-relative target.
- Jalr  input  1  from Main_Decoder: take a register-relative target.
- imm  input  XLEN  sign-extended immediate from the datapath.
- alu_result  input  XLEN  rs1+imm from the ALU, used for jalr.
- ex_done  input  1  datapath has completed the current instruction; retire it.
- misalign  output  1  only when FETCH_MISALIGN_TRAP_EN is defined; pulses one cycle.

Behaviour:
- FSM states: S_RESET, S_FETCH, S_ISSUE.
- Reset (rst=1 at an edge), from any state including mid-fetch:
  - state=S_RESET, pc=RESET_PC, instr=32'h0000_0013 (nop), instr_valid=0, imem_req=0, misalign=0.
  - An imem_ready arriving in the same cycle as rst is ignored.
- S_RESET: next cycle goes to S_FETCH unconditionally.
- S_FETCH:
  - imem_req=1, imem_addr=pc.
  - When imem_ready=1: instr<=imem_rdata, instr_valid<=1, go to S_ISSUE.
  - Stays in S_FETCH indefinitely while imem_ready=0; pc and instr are held.
  - Minimum latency is one cycle from entering S_FETCH to instr_valid=1.
- S_ISSUE:
  - imem_req=0; instr/op/F/pc held stable.
  - When ex_done=1: pc<=next_pc, instr_valid<=0, go to S_FETCH.
  - ex_done outside S_ISSUE is ignored.
- next_pc priority: Jalr=1 → {alu_result[XLEN-1:1],1'b0}; else PCSrc=1 → pc+imm; else pc+4.
  - If Jalr and PCSrc are both 1, Jalr wins.
- Arithmetic is modulo 2^XLEN; wrap-around is silent (e.g. pc=32'hFFFF_FFFC, +4 → 0).
- pc_plus4 is combinational from pc.
- op and F are combinational slices of instr, so they are valid whenever instr_valid=1.

Optional Feature:
- Macro FETCH_MISALIGN_TRAP_EN.
- Defined:
  - If next_pc[1:0]!=0 at retire, pc<=TRAP_PC instead of next_pc.
  - misalign=1 for the one cycle after that retire edge.
  - The Jalr bit-0 clear is applied before the check, so only bit 1 can trigger the trap via jalr.
- Undefined:
  - The misalign port and its logic are absent.
  - next_pc is loaded unchanged (bits [1:0] are not masked).

Decomposition:
- Shared package fetch_pkg holds:
  - state encoding localparams (S_RESET=2'd0, S_FETCH=2'd1, S_ISSUE=2'd2);
  - NOP_INSTR=32'h0000_0013;
  - field positions OP_LSB=0, OP_W=6, F_LSB=12, F_W=3.
- One sub-module: next_pc_sel, a combinational mux plus adders producing next_pc from pc, imm, alu_result, PCSrc and Jalr.

Test Plan:
- Reset then imem_ready=1 immediately with rdata=32'h0000_0033 → instr_valid=1 two cycles after rst drops; op=6'b110011, F=3'b000, pc=0.
- Sequential fetch: ex_done pulse with PCSrc=0, Jalr=0 → imem_addr=32'h4; next fetch returns 32'h0020_2023 → op=6'b100011, F=3'b010.
- Branch: pc=32'h8, PCSrc=1, imm=32'hFFFF_FFF8, ex_done → next imem_addr=32'h0.
- Jalr priority: PCSrc=1, Jalr=1, alu_result=32'h0000_0041 → next imem_addr=32'h40; pc_plus4 before retire = pc+4.
- Memory stall: hold imem_ready=0 for 5 cycles → imem_req stays 1, instr_valid=0, pc unchanged; assert rst in cycle 3 → pc=RESET_PC and the late ready is ignored.
- With FETCH_MISALIGN_TRAP_EN defined: PCSrc=1, pc=0, imm=32'h6, ex_done → pc=TRAP_PC (32'h100) and misalign=1 for exactly one cycle.
